addr_sweep_gen: RTL and testbench

Parametrised address sweep generator for the processor's memory-mapped frame and data regions. It replaces the fixed free-running region counter: it walks a configurable address window from `BASE` to `LAST` in `STRIDE` steps. Each address is presented to a downstream consumer through a valid/ready handshake. It supports single-pass and continuous (wrapping) modes, abort, and per-pass status. It sits between the control FSM, which issues start/stop, and the memory read/write port, which consumes addresses.

---
 rtl/addr_sweep_gen.sv | 101 ++++++++++
 tb/tb_addr_sweep_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_sweep_gen.sv
// Address sweep generator: walks BASE..LAST in STRIDE steps over a valid/ready
// handshake, in single-pass or continuous (wrapping) mode with per-pass status.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no sweep; valid=0, addr parked at BASE, waiting for start
// S_RUN  | sweep active; addr offered with valid=1 until accepted
module addr_sweep_gen #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned BASE   = 160000,
   parameter int unsigned LAST   = 199999,
   parameter int unsigned STRIDE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic              ready,
   output logic [ADDR_W-1:0] addr,
   output logic              valid,
   output logic              busy,
   output logic              wrap,
   output logic              done,
   output logic [7:0]        pass_count
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
   localparam logic [ADDR_W:0]   LAST_X   = (ADDR_W+1)'(LAST);
   localparam logic [ADDR_W:0]   STRIDE_X = (ADDR_W+1)'(STRIDE);

   state_t          state;
   logic            cont_mode;
   logic [ADDR_W:0] addr_next;
   logic            at_term;
   logic            accept;

   // One extra bit so a step past the top of the address space is still seen as terminal.
   assign addr_next = {1'b0, addr} + STRIDE_X;
   assign at_term   = addr_next > LAST_X;
   assign accept    = valid && ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cont_mode  <= 1'b0;
         addr       <= BASE_A;
         valid      <= 1'b0;
         busy       <= 1'b0;
         wrap       <= 1'b0;
         done       <= 1'b0;
         pass_count <= 8'd0;
      end else begin
         wrap <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !stop) begin
                  state      <= S_RUN;
                  cont_mode  <= continuous;
                  pass_count <= 8'd0;
                  addr       <= BASE_A;
                  valid      <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            S_RUN: begin
               if (stop) begin
                  state <= S_IDLE;
                  addr  <= BASE_A;
                  valid <= 1'b0;
                  busy  <= 1'b0;
               end else if (accept) begin
                  if (at_term) begin
                     wrap <= 1'b1;
                     addr <= BASE_A;
                     if (pass_count != 8'hFF)
                        pass_count <= pass_count + 8'd1;
                     if (!cont_mode) begin
                        state <= S_IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     addr <= addr_next[ADDR_W-1:0];
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addr_sweep_gen.sv
// Bench for addr_sweep_gen: four parameterisations checked every cycle against
// an index-based reference model (addr = BASE + k*STRIDE, k counts beats in a pass).
module tb_addr_sweep_gen;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start [N];
   logic        stop  [N];
   logic        cont  [N];
   logic        ready [N];
   logic [17:0] addr  [N];
   logic        valid [N];
   logic        busy  [N];
   logic        wrap  [N];
   logic        done  [N];
   logic [7:0]  pcnt  [N];

   always #5 clk = ~clk;

   addr_sweep_gen #(.ADDR_W(18), .BASE(10), .LAST(15), .STRIDE(2)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .continuous(cont[0]),
      .ready(ready[0]), .addr(addr[0]), .valid(valid[0]), .busy(busy[0]),
      .wrap(wrap[0]), .done(done[0]), .pass_count(pcnt[0]));

   addr_sweep_gen u1 (
      .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .continuous(cont[1]),
      .ready(ready[1]), .addr(addr[1]), .valid(valid[1]), .busy(busy[1]),
      .wrap(wrap[1]), .done(done[1]), .pass_count(pcnt[1]));

   addr_sweep_gen #(.ADDR_W(18), .BASE(7), .LAST(7), .STRIDE(1)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .stop(stop[2]), .continuous(cont[2]),
      .ready(ready[2]), .addr(addr[2]), .valid(valid[2]), .busy(busy[2]),
      .wrap(wrap[2]), .done(done[2]), .pass_count(pcnt[2]));

   addr_sweep_gen #(.ADDR_W(18), .BASE(262123), .LAST(262143), .STRIDE(3)) u3 (
      .clk(clk), .rst(rst), .start(start[3]), .stop(stop[3]), .continuous(cont[3]),
      .ready(ready[3]), .addr(addr[3]), .valid(valid[3]), .busy(busy[3]),
      .wrap(wrap[3]), .done(done[3]), .pass_count(pcnt[3]));

   typedef struct {
      int base;
      int last;
      int stride;
      int npass;
      bit run;
      bit cmode;
      int k;
      int passes;
      bit wrap;
      bit done;
   } model_t;

   model_t m [N];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
      end
   endtask

   task automatic mset(input int i, input int b, input int l, input int s);
      m[i].base   = b;
      m[i].last   = l;
      m[i].stride = s;
      m[i].npass  = (l - b) / s + 1;
   endtask

   task automatic mreset(input int i);
      m[i].run    = 1'b0;
      m[i].cmode  = 1'b0;
      m[i].k      = 0;
      m[i].passes = 0;
      m[i].wrap   = 1'b0;
      m[i].done   = 1'b0;
   endtask

   task automatic mstep(input int i);
      m[i].wrap = 1'b0;
      m[i].done = 1'b0;
      if (m[i].run) begin
         if (stop[i]) begin
            m[i].run = 1'b0;
            m[i].k   = 0;
         end else if (ready[i]) begin
            if (m[i].k == m[i].npass - 1) begin
               m[i].k = 0;
               m[i].passes++;
               m[i].wrap = 1'b1;
               if (!m[i].cmode) begin
                  m[i].run  = 1'b0;
                  m[i].done = 1'b1;
               end
            end else begin
               m[i].k++;
            end
         end
      end else if (start[i] && !stop[i]) begin
         m[i].run    = 1'b1;
         m[i].cmode  = cont[i];
         m[i].k      = 0;
         m[i].passes = 0;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         chk("addr", i, 32'(addr[i]), m[i].run ? 32'(m[i].base + m[i].k * m[i].stride) : 32'(m[i].base));
         chk("valid", i, 32'(valid[i]), 32'(m[i].run));
         chk("busy", i, 32'(busy[i]), 32'(m[i].run));
         chk("wrap", i, 32'(wrap[i]), 32'(m[i].wrap));
         chk("done", i, 32'(done[i]), 32'(m[i].done));
         chk("pass_count", i, 32'(pcnt[i]), 32'(m[i].passes > 255 ? 255 : m[i].passes));
      end
   endtask

   // Inputs are applied after a falling edge; model advances on the rising edge; outputs checked on the next falling edge.
   task automatic cyc();
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (rst) mreset(i);
         else mstep(i);
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic rnd(input int i, input int pstop);
      start[i] = ($urandom_range(0, 3) == 0);
      stop[i]  = ($urandom_range(0, 99) < pstop);
      cont[i]  = $urandom_range(0, 1) == 1;
      ready[i] = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle_in(input int i);
      start[i] = 1'b0;
      stop[i]  = 1'b0;
      cont[i]  = 1'b0;
      ready[i] = 1'b0;
   endtask

   initial begin
      int seen;
      for (int i = 0; i < N; i++) begin
         idle_in(i);
         mreset(i);
      end
      mset(0, 10, 15, 2);
      mset(1, 160000, 199999, 1);
      mset(2, 7, 7, 1);
      mset(3, 262123, 262143, 3);

      repeat (3) cyc();
      rst = 1'b0;
      ready[0] = 1'b1;
      repeat (2) cyc();
      chk("idle_after_rst_valid", 0, 32'(valid[0]), 32'd0);

      // single pass 10,12,14 then wrap+done together
      start[0] = 1'b1; cont[0] = 1'b0; ready[0] = 1'b1;
      cyc();
      start[0] = 1'b0;
      chk("sp_a0", 0, 32'(addr[0]), 32'd10);
      cyc();
      chk("sp_a1", 0, 32'(addr[0]), 32'd12);
      cyc();
      chk("sp_a2", 0, 32'(addr[0]), 32'd14);
      cyc();
      chk("sp_wrap", 0, 32'(wrap[0]), 32'd1);
      chk("sp_done", 0, 32'(done[0]), 32'd1);
      chk("sp_pc", 0, 32'(pcnt[0]), 32'd1);
      chk("sp_park", 0, 32'(addr[0]), 32'd10);
      // restart in the done cycle
      start[0] = 1'b1; cont[0] = 1'b1;
      cyc();
      start[0] = 1'b0;
      chk("restart_valid", 0, 32'(valid[0]), 32'd1);
      cyc();
      cyc();
      chk("pre_stop_term", 0, 32'(addr[0]), 32'd14);
      stop[0] = 1'b1;
      cyc();
      chk("stop_term_wrap", 0, 32'(wrap[0]), 32'd0);
      chk("stop_term_valid", 0, 32'(valid[0]), 32'd0);
      start[0] = 1'b1;
      cyc();
      chk("start_stop_idle", 0, 32'(busy[0]), 32'd0);
      idle_in(0);

      for (int c = 0; c < 400; c++) begin
         rnd(0, 5);
         cyc();
      end
      idle_in(0);
      stop[0] = 1'b1;
      cyc();
      idle_in(0);

      // default window: backpressure then one full continuous pass
      start[1] = 1'b1; cont[1] = 1'b1; ready[1] = 1'b1;
      cyc();
      start[1] = 1'b0;
      repeat (5) cyc();
      chk("bp_at", 1, 32'(addr[1]), 32'd160005);
      ready[1] = 1'b0;
      repeat (3) begin
         cyc();
         chk("bp_hold", 1, 32'(addr[1]), 32'd160005);
      end
      ready[1] = 1'b1;
      cyc();
      chk("bp_next", 1, 32'(addr[1]), 32'd160006);
      seen = 0;
      for (int c = 0; c < 40100 && seen == 0; c++) begin
         if (addr[1] == 18'd199999) begin
            cyc();
            seen = 1;
            chk("wrap_base", 1, 32'(addr[1]), 32'd160000);
            chk("wrap_pulse", 1, 32'(wrap[1]), 32'd1);
         end else begin
            cyc();
         end
      end
      chk("wrap_seen", 1, 32'(seen), 32'd1);
      repeat (3) cyc();
      chk("cont_busy", 1, 32'(busy[1]), 32'd1);
      chk("cont_nodone", 1, 32'(done[1]), 32'd0);
      stop[1] = 1'b1;
      cyc();
      idle_in(1);

      // abort at 160123
      start[1] = 1'b1; ready[1] = 1'b1;
      cyc();
      start[1] = 1'b0;
      repeat (123) cyc();
      chk("abort_at", 1, 32'(addr[1]), 32'd160123);
      stop[1] = 1'b1;
      cyc();
      chk("abort_addr", 1, 32'(addr[1]), 32'd160000);
      chk("abort_valid", 1, 32'(valid[1]), 32'd0);
      chk("abort_done", 1, 32'(done[1]), 32'd0);
      idle_in(1);

      // BASE==LAST: wrap every beat, pass_count saturates
      start[2] = 1'b1; cont[2] = 1'b1; ready[2] = 1'b1;
      cyc();
      start[2] = 1'b0;
      repeat (300) cyc();
      chk("sat_pc", 2, 32'(pcnt[2]), 32'd255);
      chk("sat_wrap", 2, 32'(wrap[2]), 32'd1);
      chk("sat_addr", 2, 32'(addr[2]), 32'd7);

      // top-of-space window, stride 3: TERM=262141
      start[3] = 1'b1; cont[3] = 1'b0; ready[3] = 1'b1;
      cyc();
      start[3] = 1'b0;
      repeat (6) cyc();
      chk("top_term", 3, 32'(addr[3]), 32'd262141);
      cyc();
      chk("top_done", 3, 32'(done[3]), 32'd1);
      for (int c = 0; c < 600; c++) begin
         rnd(3, 2);
         rnd(2, 3);
         cyc();
      end

      // asynchronous reset mid-sweep
      idle_in(2); idle_in(3);
      start[1] = 1'b1; cont[1] = 1'b1; ready[1] = 1'b1;
      cyc();
      start[1] = 1'b0;
      repeat (4) cyc();
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) mreset(i);
      check_all();
      chk("async_rst_addr", 1, 32'(addr[1]), 32'd160000);
      cyc();
      rst = 1'b0;
      repeat (2) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
